// File: rtl/ddc_ant_rd_intf.sv
// ddc_ant_rd_intf: pulls IQ words out of the antenna-side sync FIFO,
// decimates and optionally swaps I/Q, and presents them on an AXI-stream
// master through a small skid buffer.
// Optional feature macro: DDC_ANT_RD_SAMPLE_CNT_EN adds the sample_cnt and
// drop_cnt status counters.
module ddc_ant_rd_intf #(
    parameter int OUT_DEPTH = 4,
    parameter int DECIM_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg0,
    input  logic        ant_data_empty_n,
    output logic        ant_data_rd_en,
    input  logic [31:0] ant_data_rd_data,
    output logic [31:0] bw20_data_tdata,
    output logic        bw20_data_tvalid,
    input  logic        bw20_data_tready
`ifdef DDC_ANT_RD_SAMPLE_CNT_EN
    ,
    output logic [31:0] sample_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic               enable;
    logic               swap_en;
    logic [DECIM_W-1:0] decim_max;
    logic               unused_cfg;

    logic               inflight;
    logic [CW-1:0]      occ;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [31:0]        mem [OUT_DEPTH];
    logic [DECIM_W-1:0] dcnt;

    logic [CW:0]        credit_used;
    logic               rd_issue;
    logic               capture;
    logic               keep;
    logic               push;
    logic               pop;
    logic [31:0]        cap_word;

    assign enable     = cfg0[31];
    assign swap_en    = cfg0[4];
    assign decim_max  = cfg0[DECIM_W-1:0];
    assign unused_cfg = ^cfg0[30:DECIM_W];

    // Credit counts words already buffered, the one returning from the FIFO
    // and the read being issued right now, so the buffer can never overflow
    // even though tready has no path to rd_en.
    assign credit_used = {1'b0, occ} + (CW+1)'(inflight) + (CW+1)'(ant_data_rd_en);
    assign rd_issue    = enable & ant_data_empty_n & (credit_used < (CW+1)'(OUT_DEPTH));

    assign capture  = inflight;
    assign keep     = capture & (dcnt == '0);
    assign push     = keep;
    assign pop      = bw20_data_tvalid & bw20_data_tready;
    assign cap_word = swap_en ? {ant_data_rd_data[15:0], ant_data_rd_data[31:16]}
                              : ant_data_rd_data;

    assign bw20_data_tvalid = (occ != '0);
    assign bw20_data_tdata  = mem[rd_ptr];

    // Registered read strobe and its one-cycle-delayed in-flight flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ant_data_rd_en <= 1'b0;
            inflight       <= 1'b0;
        end else begin
            ant_data_rd_en <= rd_issue;
            inflight       <= ant_data_rd_en;
        end
    end

    // Decimation phase: advances per captured word, wraps at the configured
    // factor (or earlier if the factor shrank), and parks at 0 once disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
        end else if (capture) begin
            if (dcnt >= decim_max) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DECIM_W'(1);
            end
        end else if (!enable) begin
            dcnt <= '0;
        end
    end

    // Buffer storage; cleared on reset so tdata reads back zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= cap_word;
        end
    end

    // Circular buffer pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef DDC_ANT_RD_SAMPLE_CNT_EN
    // Status counters: accepted beats (wrapping) and dropped words (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (pop) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (capture && !keep && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A push into a full buffer without a simultaneous pop would lose data.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(occ == CW'(OUT_DEPTH) && push && !pop))
                else $error("ddc_ant_rd_intf: output buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_ddc_ant_rd_intf.sv
// Self-checking bench for ddc_ant_rd_intf: models the antenna FIFO and
// derives the expected output stream from the decimate/swap rules.
module tb_ddc_ant_rd_intf;

    localparam int OUT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg0;
    logic        empty_n;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
`ifdef DDC_ANT_RD_SAMPLE_CNT_EN
    logic [31:0] sample_cnt;
    logic [15:0] drop_cnt;
`endif

    ddc_ant_rd_intf #(.OUT_DEPTH(OUT_DEPTH), .DECIM_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg0             (cfg0),
        .ant_data_empty_n (empty_n),
        .ant_data_rd_en   (rd_en),
        .ant_data_rd_data (rd_data),
        .bw20_data_tdata  (tdata),
        .bw20_data_tvalid (tvalid),
        .bw20_data_tready (tready)
`ifdef DDC_ANT_RD_SAMPLE_CNT_EN
        ,
        .sample_cnt       (sample_cnt),
        .drop_cnt         (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] src[$];
    logic [31:0] exp_q[$];
    logic        pend_v;
    logic [31:0] pend_d;
    int          cyc, reads, beats;
    int          first_rd, first_valid, first_beat, last_beat;
    logic [31:0] first_beat_data;
    int          tr_mode;
    bit          credit_chk;
    logic        prev_hold;
    logic [31:0] prev_data;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: keep every (dec+1)-th word starting at index 0, swap halves if asked.
    task automatic build_expected(int dec, bit swap);
        exp_q.delete();
        for (int i = 0; i < src.size(); i++) begin
            if (i % (dec + 1) == 0) begin
                exp_q.push_back(swap ? {src[i][15:0], src[i][31:16]} : src[i]);
            end
        end
    endtask

    task automatic start(logic [31:0] cfg, int mode, bit credit);
        cyc = 0; reads = 0; beats = 0;
        first_rd = -1; first_valid = -1; first_beat = -1; last_beat = -1;
        prev_hold = 1'b0; tr_mode = mode; credit_chk = credit;
        pend_v = 1'b0;
        build_expected(int'(cfg[3:0]), cfg[4]);
        empty_n = (src.size() > 0);
        cfg0 = cfg;
    endtask

    // One clock: FIFO model, AXI sink with scoreboard, protocol checks.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_v) begin
            rd_data = pend_d;
            pend_v  = 1'b0;
        end
        if (rd_en) begin
            chk("rd_en_while_empty", src.size() > 0, 1);
            if (src.size() > 0) begin
                pend_d = src.pop_front();
                pend_v = 1'b1;
            end
            reads++;
            if (first_rd < 0) first_rd = cyc;
        end
        empty_n = (src.size() > 0);
        if (tvalid && first_valid < 0) first_valid = cyc;
        if (prev_hold) begin
            chk("hold_tvalid", tvalid, 1);
            chk("hold_tdata", tdata, prev_data);
        end
        if (credit_chk) chk("credit_bound", (reads - beats) <= OUT_DEPTH, 1);
        case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = pat[cyc % 4];
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", exp_q.size(), 1);
            end else begin
                chk("beat_data", tdata, exp_q.pop_front());
            end
            if (first_beat < 0) begin
                first_beat = cyc;
                first_beat_data = tdata;
            end
            last_beat = cyc;
            beats++;
        end
        prev_hold = tvalid && !tready;
        prev_data = tdata;
    endtask

    task automatic run_until_done(int budget);
        int n = 0;
        while ((src.size() > 0 || pend_v || exp_q.size() > 0 || tvalid || rd_en) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", n < budget, 1);
        repeat (4) step();
        chk("exp_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg0 = '0; empty_n = 1'b0; tready = 1'b0; rd_data = '0;
        src.delete(); exp_q.delete(); pend_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(int n);
        cfg0 = '0;
        tr_mode = 0;
        repeat (n) step();
    endtask

    initial begin
        do_reset();
        chk("reset_rd_en", rd_en, 0);
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tdata", tdata, 0);

        // Straight pass-through at full rate.
        for (int k = 0; k < 8; k++) src.push_back(32'h0001_0002 + 32'(k) * 32'h0001_0001);
        start(32'h8000_0000, 0, 1'b1);
        run_until_done(200);
        chk("first_valid_latency", first_valid - first_rd, 2);
        chk("beat_span", last_beat - first_beat, 7);
        chk("beat_count", beats, 8);

        // Decimate by 4.
        do_reset();
        for (int k = 0; k < 12; k++) src.push_back(32'(k));
        start(32'h8000_0003, 0, 1'b0);
        run_until_done(200);
        chk("decim_beats", beats, 3);
`ifdef DDC_ANT_RD_SAMPLE_CNT_EN
        chk("drop_cnt", drop_cnt, 9);
        chk("sample_cnt", sample_cnt, 3);
`endif

        // IQ swap, after a disable period that parks the decimation phase.
        idle(4);
        src.push_back(32'h1234_5678);
        for (int k = 0; k < 5; k++) src.push_back($urandom);
        start(32'h8000_0010, 0, 1'b0);
        run_until_done(200);
        chk("swap_fixed", first_beat_data, 32'h5678_1234);

        // Backpressure 1,0,0,1.
        idle(4);
        for (int k = 0; k < 20; k++) src.push_back($urandom);
        start(32'h8000_0000, 1, 1'b1);
        run_until_done(400);
        chk("bp_beats", beats, 20);

        // Random decimation, swap and tready.
        for (int r = 0; r < 3; r++) begin
            logic [31:0] c;
            idle(4);
            c = 32'h8000_0000 | 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 1)) << 4);
            for (int k = 0; k < 40; k++) src.push_back($urandom);
            start(c, 2, 1'b0);
            run_until_done(800);
        end

        // Disable in the same cycle as a read strobe.
        idle(4);
        for (int k = 0; k < 10; k++) src.push_back($urandom);
        start(32'h8000_0000, 0, 1'b1);
        begin
            int n = 0;
            while (reads < 3 && n < 50) begin
                step();
                n++;
            end
            chk("dis_reach", reads, 3);
        end
        chk("dis_rd_en_now", rd_en, 1);
        cfg0 = '0;
        while (exp_q.size() > 3 - beats) void'(exp_q.pop_back());
        repeat (20) step();
        chk("dis_reads", reads, 3);
        chk("dis_exp_left", exp_q.size(), 0);
        chk("dis_drained", tvalid, 0);
        chk("dis_src_left", src.size(), 7);

        // Asynchronous reset with occ=3 and a read in flight.
        do_reset();
        for (int k = 0; k < 10; k++) src.push_back($urandom);
        start(32'h8000_0000, 3, 1'b0);
        begin
            int n = 0;
            while (first_rd < 0 && n < 20) begin
                step();
                n++;
            end
            while (cyc < first_rd + 4 && n < 40) begin
                step();
                n++;
            end
        end
        chk("pre_rst_tvalid", tvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        src.delete(); exp_q.delete(); pend_v = 1'b0;
        empty_n = 1'b0; cfg0 = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        for (int k = 0; k < 5; k++) src.push_back(32'hA500_0000 | 32'(k));
        start(32'h8000_0000, 0, 1'b1);
        run_until_done(200);
        chk("post_rst_beats", beats, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddc_ant_rd_intf.md
Name: ddc_ant_rd_intf

Overview:
- Receive-direction counterpart of the DUC bank interface.
- Reads 32-bit IQ samples (I in [31:16], Q in [15:0]) from the antenna-side standard-mode sync FIFO.
- Optionally decimates the samples and swaps I/Q, then presents them on a bw20 AXI-stream master.
- Sits between the ADC/antenna FIFO and the DDC/receive chain; all logic runs in one clock domain.

Parameters:
- OUT_DEPTH, 4, output skid-buffer entries (power of 2, >=2; >=4 needed for 1 sample/cycle sustained).
- DECIM_W, 4, width of the decimation-factor field in cfg0.

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous active-high reset
- cfg0  in  32  [31] enable, [4] IQ swap, [3:0] decimation factor minus 1
- ant_data_empty_n  in  1  FIFO not empty
- ant_data_rd_en  out  1  FIFO read strobe; data returns 1 cycle later
- ant_data_rd_data  in  32  FIFO read data, valid the cycle after rd_en
- bw20_data_tdata  out  32  output sample
- bw20_data_tvalid  out  1  output valid
- bw20_data_tready  in  1  downstream ready

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values:
  - ant_data_rd_en=0, bw20_data_tvalid=0, bw20_data_tdata=0.
  - Buffer occupancy=0, in-flight flag=0, decimation counter=0.
- Read issue (registered):
  - ant_data_rd_en is asserted next cycle iff cfg0[31]=1 AND ant_data_empty_n=1 AND (occ + inflight + rd_en_now) < OUT_DEPTH.
  - inflight = rd_en delayed one cycle.
  - There is no combinational path from tready to rd_en.
- Capture: in the cycle after each rd_en, ant_data_rd_data is sampled exactly once (1 read = 1 captured word).
- Decimation:
  - Counter dcnt runs 0..cfg0[3:0] on each captured word.
  - A word is kept only when dcnt==0.
  - dcnt wraps to 0 after reaching cfg0[3:0].
  - cfg0[3:0]=0 keeps every word.
  - Dropped words never enter the buffer.
- IQ swap: when cfg0[4]=1, the kept word is stored as {data[15:0],data[31:16]}. The swap is applied at capture time.
- Output buffer:
  - OUT_DEPTH-entry circular FIFO.
  - tvalid = occ!=0; tdata = head entry, driven registered from storage.
  - Pop on tvalid & tready.
  - Simultaneous push and pop leaves occ unchanged.
  - Overflow is impossible by the credit rule; an assertion flags occ==OUT_DEPTH with a push and no pop.
- AXI rules:
  - Once asserted, tvalid stays high and tdata stays stable until accepted.
  - tready may toggle freely.
- Latency:
  - rd_en at cycle t, data captured at the end of t+1, tvalid at t+2 (buffer previously empty).
  - Sustained 1 word/cycle when tready=1, empty_n=1 and OUT_DEPTH>=4.
- Enable deassert (cfg0[31] 1->0):
  - No new reads issue; an in-flight read still completes and is captured.
  - Buffered data drains normally.
  - dcnt clears to 0 once inflight=0.
- A cfg0[3:0] change mid-stream takes effect on the next wrap of dcnt. If dcnt > new value, dcnt wraps to 0 on the next capture.
- FIFO empty: empty_n=0 suppresses reads only; an in-flight read is still captured.
- Reset mid-operation: all buffered and in-flight data is discarded and outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro DDC_ANT_RD_SAMPLE_CNT_EN.
- When defined:
  - Adds output port sample_cnt (out, 32): count of accepted output beats (tvalid & tready).
  - Wraps at 2^32 and resets to 0.
  - Adds output port drop_cnt (out, 16): count of decimation-dropped words, saturating at 0xFFFF.
- When undefined: both ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset then cfg0=0x80000000, FIFO holds 0x00010002..0x00080009 (8 words), tready=1 -> first tvalid 2 cycles after the first rd_en; 8 beats on consecutive cycles in order; rd_en never asserted while empty_n=0.
- cfg0=0x80000003, FIFO words 0..11 -> output words 0, 4, 8 only; drop_cnt=9 and sample_cnt=3 with the macro defined.
- cfg0=0x80000010, input 0x12345678 -> tdata=0x56781234.
- Backpressure: tready toggles 1,0,0,1 repeating over 20 words -> no loss or duplication; tdata held stable while tvalid&!tready; occ never exceeds 4; rd_en stalls when the credit is full.
- Clear cfg0[31] in the same cycle as rd_en=1 -> that word is still output; no further rd_en; the buffer drains to tvalid=0.
- Assert rst while occ=3 and inflight=1 -> tvalid=0 and rd_en=0 immediately; after release, no stale words are output.
